fir_ctrl: RTL and testbench

Sequencer for the 64-tap, 16-bit FIR datapath. It accepts one input sample per handshake and stores it in an internal 64-entry delay line. It then drives the multiply-accumulate ALU's op_code/coeff/data/prev_acc inputs for 64 consecutive cycles, reading coefficients from an external synchronous ROM. The finished 32-bit sum is captured and presented on a valid/ready output port. It is the initiator that the MAC ALU responds to.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_ctrl_if.sv | 30 +++
 rtl/fir_sample_ring.sv | 35 +++
 rtl/fir_ctrl.sv | 111 +++++++++++
 tb/tb_fir_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants, ALU op-codes and sequencer states for the FIR controller.
package fir_pkg;

  localparam int unsigned TAPS  = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 16;
  localparam int unsigned ACC_W = 32;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMac,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/fir_ctrl_if.sv
// Bundle of sample input, coefficient ROM, MAC ALU and result output signals.
// master = the sequencer, slave = the surrounding ROM/ALU/stream environment.
interface fir_ctrl_if;
  import fir_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_sample;
  logic [AW-1:0]    coeff_addr;
  logic [DW-1:0]    coeff_rdata;
  logic [1:0]       op_code;
  logic [DW-1:0]    alu_coeff;
  logic [DW-1:0]    alu_data;
  logic [ACC_W-1:0] prev_acc;
  logic [ACC_W-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    input  in_valid, in_sample, coeff_rdata, alu_result, out_ready,
    output in_ready, coeff_addr, op_code, alu_coeff, alu_data, prev_acc, out_valid, out_data
  );

  modport slave (
    output in_valid, in_sample, coeff_rdata, alu_result, out_ready,
    input  in_ready, coeff_addr, op_code, alu_coeff, alu_data, prev_acc, out_valid, out_data
  );

endinterface

// File: rtl/fir_sample_ring.sv
// Sample delay line: one write port, one registered read port whose 1-cycle
// latency matches the coefficient ROM, and asynchronous clear of all history.
module fir_sample_ring
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [TAPS];
  logic [DW-1:0] rd_data_q;

  // Storage array and registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer: accepts a sample, walks TAPS coefficient/sample pairs into the
// external MAC ALU, captures the final sum and offers it on a valid/ready port.
module fir_ctrl
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fir_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [ACC_W-1:0] out_data_q;

  logic [AW-1:0]    idx;
  logic [AW-1:0]    ring_raddr;
  logic [DW-1:0]    ring_rdata;
  logic             accept;
  logic [1:0]       op_code;
  logic [DW-1:0]    alu_coeff;
  logic [DW-1:0]    alu_data;

  fir_sample_ring u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.in_sample),
    .rd_addr_i (ring_raddr),
    .rd_data_o (ring_rdata)
  );

  // Next-state and datapath drive; idx is the tap being prefetched for next cycle.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    idx       = '0;
    op_code   = OP_CLR;
    alu_coeff = '0;
    alu_data  = '0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        idx       = k_q + AW'(1);
        alu_coeff = bus.coeff_rdata;
        alu_data  = ring_rdata;
        op_code   = (k_q == '0) ? OP_MUL : OP_MAC;
        k_d       = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tap k reads x[n-k]; AW-bit subtraction gives the mod-TAPS wrap for free.
  assign ring_raddr = base_q - idx;

  // Sequencer state, write pointer, tap counter and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      base_q     <= '0;
      wr_ptr_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        base_q   <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (state_q == StDrain) begin
        out_data_q <= bus.alu_result;
      end
    end
  end

  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.coeff_addr = idx;
  assign bus.op_code    = op_code;
  assign bus.alu_coeff  = alu_coeff;
  assign bus.alu_data   = alu_data;
  // Unregistered feedback so tap k+1 accumulates onto tap k's result.
  assign bus.prev_acc   = bus.alu_result;
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with behavioural coefficient ROM and MAC ALU.
module tb_fir_ctrl;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_ctrl_if bus ();

  fir_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DW-1:0]    rom [TAPS];
  logic signed [ACC_W-1:0] prod;

  // Synchronous coefficient ROM.
  always @(posedge clk) bus.coeff_rdata <= rom[bus.coeff_addr];

  // Registered MAC ALU.
  assign prod = $signed(bus.alu_coeff) * $signed(bus.alu_data);
  always @(posedge clk or posedge rst) begin
    if (rst) bus.alu_result <= '0;
    else begin
      case (bus.op_code)
        2'b00:   bus.alu_result <= '0;
        2'b01:   bus.alu_result <= prod;
        2'b10:   bus.alu_result <= bus.prev_acc + prod;
        default: bus.alu_result <= 'x;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for in_ready, hands over one sample, then tracks the op-code stream
  // until out_valid; lat is the cycle index of out_valid after acceptance.
  task automatic run_sample(input logic [DW-1:0] x, output logic [ACC_W-1:0] y,
                            output int lat, output int op_err);
    int w = 0;
    logic [1:0] exp_op;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_sample = x;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    op_err = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      exp_op = (c == 2) ? 2'b01 : ((c >= 3 && c <= 65) ? 2'b10 : 2'b00);
      if (bus.op_code !== exp_op) op_err++;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    y = bus.out_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready_low got %b want 0", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready_high got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data);
    end
    n_cmp++;
    if (bus.op_code !== 2'b00 || bus.coeff_addr !== 6'd0) begin
      n_bad++; $display("FAIL reset_op_addr got op=%b addr=%0d want 00/0",
                        bus.op_code, bus.coeff_addr);
    end
    n_cmp++;
    if (bus.alu_coeff !== 16'h0 || bus.alu_data !== 16'h0) begin
      n_bad++; $display("FAIL reset_alu_ops got %h/%h want 0/0", bus.alu_coeff, bus.alu_data);
    end
    n_cmp++;
    if (bus.prev_acc !== 32'h0) begin
      n_bad++; $display("FAIL reset_prev_acc got %h want 0", bus.prev_acc);
    end
  endtask

  task automatic test_impulse();
    logic [ACC_W-1:0] y;
    int lat, oe;
    for (int k = 0; k < int'(TAPS); k++) rom[k] = 16'(k + 1);
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      run_sample((n == 0) ? 16'd1 : 16'd0, y, lat, oe);
      n_cmp++;
      if (y !== 32'(n + 1)) begin
        n_bad++; $display("FAIL impulse_y[%0d] got %0d want %0d", n, y, n + 1);
      end
      n_cmp++;
      if (lat !== 67) begin
        n_bad++; $display("FAIL impulse_lat[%0d] got %0d want 67", n, lat);
      end
      n_cmp++;
      if (oe !== 0) begin
        n_bad++; $display("FAIL impulse_opseq[%0d] got %0d bad cycles want 0", n, oe);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ACC_W-1:0] y, e;
    int lat, oe;
    for (int k = 0; k < int'(TAPS); k++) rom[k] = 16'sd1;
    apply_reset();
    for (int n = 0; n < 130; n++) begin
      run_sample(16'd2, y, lat, oe);
      e = (n < 64) ? 32'(2 * (n + 1)) : 32'd128;
      n_cmp++;
      if (y !== e) begin
        n_bad++; $display("FAIL wrap_y[%0d] got %0d want %0d", n, y, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] y, e;
    int lat, oe;
    for (int k = 0; k < int'(TAPS); k++) rom[k] = 16'sh8000;
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      run_sample(16'h8000, y, lat, oe);
      e = 32'(n + 1) << 30;
      n_cmp++;
      if (y !== e) begin
        n_bad++; $display("FAIL overflow_y[%0d] got %h want %h", n, y, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [ACC_W-1:0] y;
    int lat, oe;
    for (int k = 0; k < int'(TAPS); k++) rom[k] = 16'(k + 1);
    apply_reset();
    run_sample(16'd3, y, lat, oe);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sample = 16'd4;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.op_code !== 2'b00 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midreset_abort got ov=%b op=%b ir=%b want 0/00/0",
                        bus.out_valid, bus.op_code, bus.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_in_ready got %b want 1", bus.in_ready);
    end
    run_sample(16'd1, y, lat, oe);
    n_cmp++;
    if (y !== 32'd1) begin
      n_bad++; $display("FAIL midreset_fresh0 got %0d want 1", y);
    end
    run_sample(16'd0, y, lat, oe);
    n_cmp++;
    if (y !== 32'd2) begin
      n_bad++; $display("FAIL midreset_fresh1 got %0d want 2", y);
    end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] y;
    int lat, oe, w;
    for (int k = 0; k < int'(TAPS); k++) rom[k] = 16'(k + 1);
    apply_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sample = 16'd5;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd5) begin
      n_bad++; $display("FAIL bp_first got ov=%b y=%0d want 1/5", bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd5 || bus.in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] got ov=%b y=%0d ir=%b want 1/5/0",
                          i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      bus.in_valid = (i % 4 == 0);
      bus.in_sample = 16'd7;
    end
    // Release in the same cycle a new sample is offered.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sample = 16'd9;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_release_in_ready got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_idle got ir=%b ov=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    n_cmp++;
    if (lat !== 67 || bus.out_data !== 32'd19) begin
      n_bad++; $display("FAIL bp_next got lat=%0d y=%0d want 67/19", lat, bus.out_data);
    end
    run_sample(16'd0, y, lat, oe);
    n_cmp++;
    if (y !== 32'd33) begin
      n_bad++; $display("FAIL bp_single_advance got %0d want 33", y);
    end
  endtask

  initial begin
    for (int k = 0; k < int'(TAPS); k++) rom[k] = '0;
    test_reset();
    test_impulse();
    test_wrap();
    test_overflow();
    test_reset_mid();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
